regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file write-back arbiter: per-port request FIFOs, round-robin
// pop onto one registered write port, and a pending-write bitmap.
module regfile_wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_reg,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_reg,
   input  logic [31:0] b_data,
   output logic        wr_en,
   output logic [4:0]  wr_reg,
   output logic [31:0] wr_data,
   output logic [31:0] pend
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [1:0]       w_in_valid;
   logic [1:0][4:0]  w_in_reg;
   logic [1:0][31:0] w_in_data;
   logic [1:0]       w_ready;
   logic [1:0]       w_nonempty;
   logic [1:0]       w_pop;
   logic [1:0][4:0]  w_head_reg;
   logic [1:0][31:0] w_head_data;
   logic [1:0][31:0] w_fifo_pend;
   logic             w_any;
   logic             w_sel;
   logic [31:0]      w_pend;

   logic             r_last;
   logic             r_wr_en;
   logic [4:0]       r_wr_reg;
   logic [31:0]      r_wr_data;

   assign w_in_valid = {b_valid, a_valid};
   assign w_in_reg   = {b_reg, a_reg};
   assign w_in_data  = {b_data, a_data};

   genvar gi;
   genvar gj;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [AW-1:0]    r_wptr;
         logic [AW-1:0]    r_rptr;
         logic [AW:0]      r_count;
         logic [4:0]       r_mem_reg  [DEPTH];
         logic [31:0]      r_mem_data [DEPTH];
         logic [DEPTH-1:0] w_ent_valid;
         logic [31:0]      w_hit;
         logic             w_push;

         // Ready looks only at the start-of-cycle count, so a full FIFO stays
         // closed even when its head is being popped this cycle.
         assign w_ready[gi]     = (r_count != CNT_FULL) && !clr;
         assign w_push          = w_in_valid[gi] && w_ready[gi];
         assign w_nonempty[gi]  = (r_count != '0);
         assign w_head_reg[gi]  = r_mem_reg[r_rptr];
         assign w_head_data[gi] = r_mem_data[r_rptr];

         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end else begin
               if (w_push)
                  r_wptr <= r_wptr + 1'b1;
               if (w_pop[gi])
                  r_rptr <= r_rptr + 1'b1;
               r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop[gi]};
            end
         end

         always_ff @(posedge clk) begin
            if (w_push) begin
               r_mem_reg[r_wptr]  <= w_in_reg[gi];
               r_mem_data[r_wptr] <= w_in_data[gi];
            end
         end

         // An entry is live when its distance from the read pointer is below the count.
         for (gj = 0; gj < DEPTH; gj++) begin : g_ent
            assign w_ent_valid[gj] = {1'b0, AW'(gj) - r_rptr} < r_count;
         end

         always_comb begin
            w_hit = '0;
            for (int e = 0; e < DEPTH; e++) begin
               if (w_ent_valid[e])
                  w_hit[r_mem_reg[e]] = 1'b1;
            end
         end

         assign w_fifo_pend[gi] = w_hit;
      end
   endgenerate

   always_comb begin
      w_any = |w_nonempty;
      w_sel = w_nonempty[1];
      if (&w_nonempty)
         w_sel = !r_last;
      w_pop = '0;
      if (w_any)
         w_pop[w_sel] = 1'b1;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_wr_en   <= 1'b0;
         r_wr_reg  <= '0;
         r_wr_data <= '0;
         r_last    <= 1'b1;
      end else begin
         // Writes to r0 are drained from the queue but never reach the register file.
         r_wr_en <= w_any && (w_head_reg[w_sel] != 5'd0);
         if (w_any) begin
            r_wr_reg  <= w_head_reg[w_sel];
            r_wr_data <= w_head_data[w_sel];
            r_last    <= w_sel;
         end
      end
   end

   always_comb begin
      w_pend = w_fifo_pend[0] | w_fifo_pend[1];
      if (r_wr_en)
         w_pend[r_wr_reg] = 1'b1;
      w_pend[0] = 1'b0;
   end

   assign a_ready = w_ready[0];
   assign b_ready = w_ready[1];
   assign wr_en   = r_wr_en;
   assign wr_reg  = r_wr_reg;
   assign wr_data = r_wr_data;
   assign pend    = w_pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-scenario tasks plus a
// scoreboard of expected register-file writes consumed by a write monitor.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 2;

   logic        clk;
   logic        clr;
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_reg;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_reg;
   logic [31:0] b_data;
   logic        wr_en;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [31:0] pend;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .clr     (clr),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_reg   (a_reg),
      .a_data  (a_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_reg   (b_reg),
      .b_data  (b_data),
      .wr_en   (wr_en),
      .wr_reg  (wr_reg),
      .wr_data (wr_data),
      .pend    (pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every visible write must match the oldest expected write.
   always @(negedge clk) begin : mon
      logic [36:0] e;
      if (wr_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got reg %0d data %h, required no write", wr_reg, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_reg, wr_data} !== e) begin
               errors++;
               $display("FAIL write_order: got reg %0d data %h, required reg %0d data %h",
                        wr_reg, wr_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({wr_en, a_ready, b_ready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: got wr_en/a_ready/b_ready %b, required 000", {wr_en, a_ready, b_ready});
      end
      checks++;
      if ({wr_reg, wr_data, pend} !== 69'd0) begin
         errors++;
         $display("FAIL reset_data: got wr_reg %h wr_data %h pend %h, required all zero", wr_reg, wr_data, pend);
      end
      clr = 1'b0;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b11) begin
         errors++;
         $display("FAIL release_ready: got %b, required 11", {a_ready, b_ready});
      end
   endtask

   task automatic test_single();
      a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b0 || pend !== 32'h0000_0020) begin
         errors++;
         $display("FAIL single_e1: got wr_en %b pend %h, required 0 00000020", wr_en, pend);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_reg !== 5'd5 || wr_data !== 32'hDEADBEEF || pend !== 32'h0000_0020) begin
         errors++;
         $display("FAIL single_e2: got %b %0d %h pend %h, required 1 5 deadbeef 00000020", wr_en, wr_reg, wr_data, pend);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || pend !== 32'h0) begin
         errors++;
         $display("FAIL single_e3: got wr_en %b pend %h, required 0 00000000", wr_en, pend);
      end
   endtask

   task automatic test_tie();
      do_reset();
      a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h0000_1111;
      b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h0000_2222;
      exp_q.push_back({5'd1, 32'h0000_1111});
      exp_q.push_back({5'd2, 32'h0000_2222});
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_reg !== 5'd1) begin
         errors++;
         $display("FAIL tie_first: got wr_en %b reg %0d, required 1 1", wr_en, wr_reg);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_reg !== 5'd2) begin
         errors++;
         $display("FAIL tie_second: got wr_en %b reg %0d, required 1 2", wr_en, wr_reg);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("FAIL tie_idle: got wr_en %b, required 0", wr_en);
      end
   endtask

   task automatic test_reg0();
      a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h0000_0001;
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || pend !== 32'h0) begin
         errors++;
         $display("FAIL reg0_queued: got wr_en %b pend %h, required 0 00000000", wr_en, pend);
      end
      a_reg = 5'd3; a_data = 32'h3333_0003;
      exp_q.push_back({5'd3, 32'h3333_0003});
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'h1 || pend !== 32'h0000_0008) begin
         errors++;
         $display("FAIL reg0_consumed: got %b %0d %h pend %h, required 0 0 00000001 00000008", wr_en, wr_reg, wr_data, pend);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_reg !== 5'd3) begin
         errors++;
         $display("FAIL reg0_follow: got wr_en %b reg %0d, required 1 3", wr_en, wr_reg);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || pend !== 32'h0) begin
         errors++;
         $display("FAIL reg0_idle: got wr_en %b pend %h, required 0 00000000", wr_en, pend);
      end
   endtask

   task automatic test_order();
      a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h11;
      exp_q.push_back({5'd7, 32'h11});
      @(negedge clk);
      checks++;
      if (pend !== 32'h0000_0080) begin
         errors++;
         $display("FAIL order_pend1: got %h, required 00000080", pend);
      end
      a_data = 32'h22;
      exp_q.push_back({5'd7, 32'h22});
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 32'h11 || pend !== 32'h0000_0080) begin
         errors++;
         $display("FAIL order_first: got %b %h pend %h, required 1 00000011 00000080", wr_en, wr_data, pend);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 32'h22 || pend !== 32'h0000_0080) begin
         errors++;
         $display("FAIL order_second: got %b %h pend %h, required 1 00000022 00000080", wr_en, wr_data, pend);
      end
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || pend !== 32'h0) begin
         errors++;
         $display("FAIL order_done: got wr_en %b pend %h, required 0 00000000", wr_en, pend);
      end
   endtask

   // Both ports push continuously; a small occupancy/round-robin model predicts
   // ready and the order in which writes must leave.
   task automatic test_backpressure();
      logic [36:0] qa[$];
      logic [36:0] qb[$];
      logic [36:0] e;
      int  mc_a, mc_b, sent_a, sent_b;
      bit  mlast, ra, rb, pa, pb, ne_a, ne_b, sel;
      do_reset();
      mc_a = 0; mc_b = 0; sent_a = 0; sent_b = 0; mlast = 1'b1;
      for (int c = 0; c < 20; c++) begin
         a_valid = (sent_a < 6); a_reg = 5'(10 + sent_a); a_data = 32'hA000_0000 + 32'(sent_a);
         b_valid = (sent_b < 6); b_reg = 5'(20 + sent_b); b_data = 32'hB000_0000 + 32'(sent_b);
         #1;
         ra = (mc_a != DEPTH);
         rb = (mc_b != DEPTH);
         checks++;
         if (a_ready !== ra) begin
            errors++;
            $display("FAIL bp_a_ready cycle %0d: got %b, required %b (count %0d)", c, a_ready, ra, mc_a);
         end
         checks++;
         if (b_ready !== rb) begin
            errors++;
            $display("FAIL bp_b_ready cycle %0d: got %b, required %b (count %0d)", c, b_ready, rb, mc_b);
         end
         pa = a_valid && ra;
         pb = b_valid && rb;
         ne_a = (mc_a != 0);
         ne_b = (mc_b != 0);
         sel = (ne_a && ne_b) ? !mlast : ne_b;
         if (ne_a || ne_b) begin
            if (!sel) begin e = qa.pop_front(); mc_a--; end
            else      begin e = qb.pop_front(); mc_b--; end
            exp_q.push_back(e);
            mlast = sel;
         end
         if (pa) begin qa.push_back({a_reg, a_data}); mc_a++; sent_a++; end
         if (pb) begin qb.push_back({b_reg, b_data}); mc_b++; sent_b++; end
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      a_valid = 1'b1; a_reg = 5'd12; a_data = 32'hA0;
      b_valid = 1'b1; b_reg = 5'd22; b_data = 32'hB0;
      exp_q.push_back({5'd12, 32'hA0});
      @(negedge clk);
      a_reg = 5'd13; a_data = 32'hA1;
      b_reg = 5'd23; b_data = 32'hB1;
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b1 || {a_ready, b_ready} !== 2'b10 || pend !== 32'h00C0_3000) begin
         errors++;
         $display("FAIL mid_loaded: got wr_en %b ready %b pend %h, required 1 10 00c03000", wr_en, {a_ready, b_ready}, pend);
      end
      #2 clr = 1'b1;
      #1;
      checks++;
      if ({wr_en, a_ready, b_ready} !== 3'b000 || pend !== 32'h0 || wr_reg !== 5'd0 || wr_data !== 32'h0) begin
         errors++;
         $display("FAIL mid_clr_async: got %b pend %h reg %0d data %h, required 000 0 0 0",
                  {wr_en, a_ready, b_ready}, pend, wr_reg, wr_data);
      end
      @(negedge clk);
      checks++;
      if ({wr_en, a_ready, b_ready} !== 3'b000 || pend !== 32'h0) begin
         errors++;
         $display("FAIL mid_clr_held: got %b pend %h, required 000 00000000", {wr_en, a_ready, b_ready}, pend);
      end
      clr = 1'b0;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b11) begin
         errors++;
         $display("FAIL mid_release_ready: got %b, required 11", {a_ready, b_ready});
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (wr_en !== 1'b0 || pend !== 32'h0) begin
            errors++;
            $display("FAIL mid_stale cycle %0d: got wr_en %b pend %h, required 0 00000000", c, wr_en, pend);
         end
      end
   endtask

   initial begin
      clr = 1'b1;
      a_valid = 1'b0; a_reg = '0; a_data = '0;
      b_valid = 1'b0; b_reg = '0; b_data = '0;
      test_reset();
      test_single();
      test_tie();
      test_reg0();
      test_order();
      test_backpressure();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d writes still expected, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
